// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for a pipelined CPU
// MEM stage. A request is accepted in IDLE and answered after a fixed latency.
// The response is held stable until the CPU takes it.
//
// Handshake rules, both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1. The requester holds valid and payload
// until that edge. The responder holds rsp_valid, rsp_rdata and rsp_err
// stable until rsp_ready is sampled high.
module dmem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] done_cnt,
    output logic [1:0]  dbg_state
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  l_we;
    logic [31:0]           l_addr;
    logic [31:0]           l_wdata;
    logic [3:0]            l_be;

    logic [31:0]           mem [DEPTH];

    logic [32:0]           diff;
    logic                  in_range;
    logic                  fault;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  resolve;

    // Range check on the latched address; the extra top bit of diff flags an
    // address below BASE_ADDR so it counts as out of range.
    assign diff     = {1'b0, l_addr} - {1'b0, BASE_ADDR};
    assign in_range = !diff[32] && ((diff[31:0] >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign fault    = (l_addr[1:0] != 2'b00) || !in_range;
    assign idx      = diff[DEPTH_LOG2+1:2];

    // WAIT always spends at least one cycle, so the response lands LATENCY+1
    // edges after the accept edge; the access resolves on the last WAIT edge.
    assign resolve   = (state == WAIT) && (cnt == 4'd0);
    assign req_ready = rst && (state == IDLE);
    assign dbg_state = state;

    // Request/response sequencing with registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            l_we      <= 1'b0;
            l_addr    <= 32'd0;
            l_wdata   <= 32'd0;
            l_be      <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            done_cnt  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_we    <= req_we;
                        l_addr  <= req_addr;
                        l_wdata <= req_wdata;
                        l_be    <= req_be;
                        cnt     <= LAT;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= fault;
                        rsp_rdata <= (fault || l_we) ? 32'd0 : mem[idx];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        if (done_cnt != 16'hFFFF) begin
                            done_cnt <= done_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte-masked store commit; reset forces IDLE so a dropped store never writes.
    always_ff @(posedge clk) begin
        if (resolve && l_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (l_be[i]) begin
                    mem[idx][8*i +: 8] <= l_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
